// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_pkg: shared op encodings, FSM states and iteration count.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [1:0] MDU_NONE = 2'b00;
  localparam logic [1:0] MDU_MULT = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_step: one shift-add (mult) or restoring shift-subtract (div).   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic [1:0]         i_op,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc_nxt
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Accumulator is {upper, lower}: mult keeps {partial product, multiplier},
  // div keeps {remainder, dividend/quotient}.  A set diff MSB means borrow.
  always_comb begin
    w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_rem_sh - {1'b0, i_opnd};
    o_acc_nxt = {w_sum, i_acc[WIDTH-1:1]};
    if (i_op == MDU_DIV) begin
      if (w_diff[WIDTH]) begin
        o_acc_nxt = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else begin
        o_acc_nxt = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_div_unit: multicycle signed multiply/divide writing HI/LO.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mult_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div0;

  logic               w_cmd_mult;
  logic               w_cmd_div;
  logic               w_cmd_valid;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op      (r_op),
    .i_acc     (r_acc),
    .i_opnd    (r_opnd),
    .o_acc_nxt (w_acc_nxt)
  );

  always_comb begin
    w_cmd_mult  = (mult_div == MDU_MULT);
    w_cmd_div   = (mult_div == MDU_DIV);
    w_cmd_valid = w_cmd_mult | w_cmd_div;
    w_a_mag     = a[WIDTH-1] ? -a : a;
    w_b_mag     = b[WIDTH-1] ? -b : b;
  end

  // Quotient/product take the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    w_prod   = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_quot   = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    w_rem    = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_op == MDU_DIV) begin
      w_hi_fix = w_rem;
      w_lo_fix = w_quot;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= MDU_NONE;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_div && (b == '0)) begin
            r_done  <= 1'b1;
            r_div0  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_cmd_valid) begin
            r_op    <= mult_div;
            r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r <= a[WIDTH-1];
            r_opnd  <= w_cmd_div ? w_b_mag : w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, (w_cmd_div ? w_a_mag : w_b_mag)};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_hi    <= w_hi_fix;
            r_lo    <= w_lo_fix;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= w_cmd_valid ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (!w_cmd_valid) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mult_div_unit: vector table, random ops vs. arithmetic model.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mult_div = MDU_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .mult_div (mult_div),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div0     (div0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        ed0;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] eh, output logic [31:0] el, output logic ed0);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    eh  = m_hi;
    el  = m_lo;
    ed0 = 1'b0;
    if (op == MDU_MULT) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (op == MDU_DIV) begin
      if (sb == 0) begin
        ed0 = 1'b1;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        eh = r[31:0];
        el = q[31:0];
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed0,
                        input string tag);
    int lat, nbusy;
    mult_div = op;
    a = av;
    b = bv;
    tick();
    mult_div = MDU_NONE;
    a = $urandom;
    b = $urandom;
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      nbusy += int'(busy);
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), ed0 ? 64'd1 : 64'd33);
    check({tag, " busy_cycles"}, 64'(nbusy), ed0 ? 64'd0 : 64'd32);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " div0"}, 64'(div0), 64'(ed0));
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    tick();
    check({tag, " done_pulse"}, {62'd0, done, div0}, 64'd0);
    check({tag, " hold_lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic        ed0;
    logic [1:0]  rop;
    int          ndone, nbusy, lat;

    vecs[0]  = '{MDU_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{MDU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{MDU_DIV,  32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0};
    vecs[5]  = '{MDU_DIV,  32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1};
    vecs[6]  = '{MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[7]  = '{MDU_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{MDU_MULT, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{MDU_DIV,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[10] = '{MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};

    repeat (3) tick();
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].ehi, vecs[i].elo, vecs[i].ed0,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(1, 2));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($signed(32'($urandom_range(0, 15))) - 8);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      ref_model(rop, ra, rb, eh, el, ed0);
      run_op(rop, ra, rb, eh, el, ed0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Held command: one completion, then the unit parks until the command drops.
    ra = 32'h1234_5678;
    rb = 32'hFEDC_BA98;
    ref_model(MDU_MULT, ra, rb, eh, el, ed0);
    mult_div = MDU_MULT;
    a = ra;
    b = rb;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      ndone += int'(done);
      nbusy += int'(busy);
    end
    check("hold done_count", 64'(ndone), 64'd1);
    check("hold busy_count", 64'(nbusy), 64'd32);
    check("hold parked", {62'd0, busy, done}, 64'd0);
    check("hold hi", 64'(hi), 64'(eh));
    check("hold lo", 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
    mult_div = MDU_NONE;
    tick();
    ref_model(MDU_MULT, 32'd9, 32'hFFFF_FFF0, eh, el, ed0);
    run_op(MDU_MULT, 32'd9, 32'hFFFF_FFF0, eh, el, ed0, "reissue");

    // Reset mid-operation with the command still applied.
    mult_div = MDU_MULT;
    a = 32'd3;
    b = 32'd5;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy_done", {62'd0, busy, done}, 64'd0);
    tick();
    check("rst_vs_cmd busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst busy", 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    mult_div = MDU_NONE;
    check("post_rst latency", 64'(lat), 64'd33);
    check("post_rst hi", 64'(hi), 64'd0);
    check("post_rst lo", 64'(lo), 64'd15);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
